// File: rtl/alu_decode_stage_pkg.sv
// Shared WISC decode constants: 5-bit opcodes, 4-bit ALU op codes (same
// encoding the ALU uses), branch-type codes and the decoded-slot payload.
package alu_decode_stage_pkg;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_SHF_R = 5'b11010;
  localparam logic [4:0] OP_ARI_R = 5'b11011;

  localparam logic [3:0] ALU_SUB  = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_ANDN = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;
  localparam logic [3:0] ALU_ROL  = 4'h4;
  localparam logic [3:0] ALU_BTR  = 4'h8;
  localparam logic [3:0] ALU_SEQ  = 4'h9;
  localparam logic [3:0] ALU_PASS = 4'hD;
  localparam logic [3:0] ALU_SLBI = 4'hE;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQZ  = 2'b01;
  localparam logic [1:0] BR_NEZ  = 2'b10;
  localparam logic [1:0] BR_SIGN = 2'b11;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [15:0] imm;
    logic        b_sel_imm;
    logic        swap_ab;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  branch;
    logic        halt;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/wisc_decode_comb.sv
// Purely combinational WISC instruction decoder: instruction word in,
// ALU/memory/branch control fields out.
module wisc_decode_comb
  import alu_decode_stage_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic [IW-1:0] instr,
  output dec_t          dec
);

  logic [4:0]  op;
  logic [15:0] imm5_s, imm5_z, imm8_s, imm8_z;

  assign op     = instr[15:11];
  assign imm5_s = {{11{instr[4]}}, instr[4:0]};
  assign imm5_z = {11'd0, instr[4:0]};
  assign imm8_s = {{8{instr[7]}}, instr[7:0]};
  assign imm8_z = {8'd0, instr[7:0]};

  always_comb begin
    dec    = '0;
    dec.rs = instr[10:8];
    dec.rt = instr[7:5];
    dec.rd = instr[7:5];
    casez (op)
      OP_HALT: dec.halt = 1'b1;
      OP_NOP:  ;
      OP_ADDI, OP_SUBI: begin
        dec.alu_op    = (op == OP_ADDI) ? ALU_ADD : ALU_SUB;
        dec.swap_ab   = (op == OP_SUBI);
        dec.imm       = imm5_s;
        dec.b_sel_imm = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_XORI, OP_ANDNI: begin
        dec.alu_op    = (op == OP_XORI) ? ALU_XOR : ALU_ANDN;
        dec.imm       = imm5_z;
        dec.b_sel_imm = 1'b1;
        dec.reg_write = 1'b1;
      end
      5'b101??: begin
        dec.alu_op    = ALU_ROL | {2'b00, op[1:0]};
        dec.imm       = imm5_z;
        dec.b_sel_imm = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_ST, OP_LD, OP_STU: begin
        dec.alu_op    = ALU_ADD;
        dec.imm       = imm5_s;
        dec.b_sel_imm = 1'b1;
        dec.mem_read  = (op == OP_LD);
        dec.mem_write = (op != OP_LD);
        dec.reg_write = (op != OP_ST);
        // STU writes the updated address back into the base register
        if (op == OP_STU) dec.rd = instr[10:8];
      end
      OP_LBI, OP_SLBI: begin
        dec.alu_op    = (op == OP_LBI) ? ALU_PASS : ALU_SLBI;
        dec.imm       = (op == OP_LBI) ? imm8_s : imm8_z;
        dec.b_sel_imm = 1'b1;
        dec.reg_write = 1'b1;
        dec.rd        = instr[10:8];
      end
      5'b011??: begin
        dec.alu_op    = ALU_PASS;
        dec.imm       = imm8_s;
        dec.b_sel_imm = 1'b1;
        dec.branch    = op[1] ? BR_SIGN : (op[0] ? BR_NEZ : BR_EQZ);
      end
      OP_ARI_R: begin
        case (instr[1:0])
          2'b00:   dec.alu_op = ALU_ADD;
          2'b01:   dec.alu_op = ALU_SUB;
          2'b10:   dec.alu_op = ALU_XOR;
          default: dec.alu_op = ALU_ANDN;
        endcase
        dec.swap_ab   = (instr[1:0] == 2'b01);
        dec.reg_write = 1'b1;
        dec.rd        = instr[4:2];
      end
      OP_SHF_R, OP_BTR, 5'b111??: begin
        if (op == OP_SHF_R)   dec.alu_op = ALU_ROL | {2'b00, instr[1:0]};
        else if (op == OP_BTR) dec.alu_op = ALU_BTR;
        else                  dec.alu_op = ALU_SEQ + {2'b00, op[1:0]};
        dec.reg_write = 1'b1;
        dec.rd        = instr[4:2];
      end
      default: begin
        // jumps, siic, rti: flagged, no side effects
        dec         = '0;
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// ID/EX pipeline slot for the WISC ALU: decodes fetched instructions and
// holds the result behind a valid/ready handshake, with flush and HALT.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] instr,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    alu_op,
  output logic [IW-1:0] imm,
  output logic          b_sel_imm,
  output logic          swap_ab,
  output logic [2:0]    rs,
  output logic [2:0]    rt,
  output logic [2:0]    rd,
  output logic          reg_write,
  output logic          mem_read,
  output logic          mem_write,
  output logic [1:0]    branch,
  output logic          halt,
  output logic          illegal
);

  dec_t dec_next, slot;
  logic halted;
  logic take;

  wisc_decode_comb #(.IW(IW)) u_decode (
    .instr (instr),
    .dec   (dec_next)
  );

  // Handshake: a word moves on any cycle where valid and ready are both high;
  // neither side may make valid depend on ready. The slot can be refilled in
  // the same cycle execute drains it. Once HALT is taken nothing more enters.
  assign in_ready = ~halted & (~out_valid | out_ready);
  assign take     = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      slot      <= '0;
      halted    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      slot      <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      slot      <= dec_next;
      if (dec_next.halt) halted <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_op    = slot.alu_op;
  assign imm       = slot.imm;
  assign b_sel_imm = slot.b_sel_imm;
  assign swap_ab   = slot.swap_ab;
  assign rs        = slot.rs;
  assign rt        = slot.rt;
  assign rd        = slot.rd;
  assign reg_write = slot.reg_write;
  assign mem_read  = slot.mem_read;
  assign mem_write = slot.mem_write;
  assign branch    = slot.branch;
  assign halt      = slot.halt;
  assign illegal   = slot.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: hand-decoded WISC words, backpressure,
// flush, HALT and reset recovery.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] instr, imm;
  logic [3:0]  alu_op;
  logic        b_sel_imm, swap_ab, reg_write, mem_read, mem_write, halt, illegal;
  logic [2:0]  rs, rt, rd;
  logic [1:0]  branch;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_decode_stage #(.IW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .imm(imm), .b_sel_imm(b_sel_imm), .swap_ab(swap_ab),
    .rs(rs), .rt(rt), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .halt(halt), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] word);
    instr     = word;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; instr = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_imm", imm, 0);
    chk("rst_halt", halt, 0);
    rst_n = 1'b1; #1;
    chk("rst_in_ready", in_ready, 1);

    send(16'hD94C);
    chk("add_valid", out_valid, 1);
    chk("add_op", alu_op, 16'h1);
    chk("add_rs", rs, 1);
    chk("add_rt", rt, 2);
    chk("add_rd", rd, 3);
    chk("add_wr", reg_write, 1);
    chk("add_bsel", b_sel_imm, 0);

    send(16'h415F);
    chk("addi_op", alu_op, 16'h1);
    chk("addi_imm", imm, 16'hFFFF);
    chk("addi_bsel", b_sel_imm, 1);
    chk("addi_rd", rd, 2);

    send(16'h515F);
    chk("xori_op", alu_op, 16'h3);
    chk("xori_imm", imm, 16'h001F);

    send(16'hD94D);
    chk("sub_op", alu_op, 16'h0);
    chk("sub_swap", swap_ab, 1);

    send(16'hC480);
    chk("lbi_op", alu_op, 16'hD);
    chk("lbi_imm", imm, 16'hFF80);
    chk("lbi_rd", rd, 4);

    send(16'h9480);
    chk("slbi_op", alu_op, 16'hE);
    chk("slbi_imm", imm, 16'h0080);
    chk("slbi_rd", rd, 4);

    send(16'h8943);
    chk("ld_rd", mem_read, 1);
    chk("ld_imm", imm, 16'h0003);
    chk("ld_dst", rd, 2);

    send(16'h995E);
    chk("stu_wr", mem_write, 1);
    chk("stu_rw", reg_write, 1);
    chk("stu_rd", rd, 1);
    chk("stu_imm", imm, 16'hFFFE);

    send(16'h6BFE);
    chk("bnez_br", branch, 2'b10);
    chk("bnez_op", alu_op, 16'hD);
    chk("bnez_imm", imm, 16'hFFFE);
    chk("bnez_rw", reg_write, 0);

    send(16'h3000);
    chk("jal_ill", illegal, 1);
    chk("jal_valid", out_valid, 1);
    chk("jal_rw", reg_write, 0);

    // backpressure: SLLI held for three cycles while XORI waits
    send(16'hA943);
    chk("slli_op", alu_op, 16'h5);
    out_ready = 1'b0; instr = 16'h515F; #1;
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_op", alu_op, 16'h5);
      chk("bp_imm", imm, 16'h0003);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_next_op", alu_op, 16'h3);
    chk("bp_next_imm", imm, 16'h001F);

    // flush with a held slot and a concurrent ADD transfer
    instr = 16'hD94C; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    tick();
    chk("flush_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_gone_valid", out_valid, 0);
    chk("flush_gone_op", alu_op, 0);

    // consume without refill
    send(16'h0800);
    chk("nop_valid", out_valid, 1);
    chk("nop_rw", reg_write, 0);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);

    // HALT locks the input side until reset
    send(16'h0000);
    chk("halt_flag", halt, 1);
    chk("halt_valid", out_valid, 1);
    chk("halt_rw", reg_write, 0);
    chk("halt_in_ready", in_ready, 0);
    instr = 16'hD94C;
    tick();
    chk("halted_drain", out_valid, 0);
    chk("halted_ready", in_ready, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    chk("halted_after_flush", in_ready, 0);

    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    chk("rst2_valid", out_valid, 0);
    chk("rst2_halt", halt, 0);
    chk("rst2_op", alu_op, 0);
    rst_n = 1'b1; #1;
    chk("rst2_in_ready", in_ready, 1);

    send(16'hD94C);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_op", alu_op, 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
